// File: rtl/ssm_word_demux_arb.sv
// Routes the shared codec word stream into per-substream word buffers, in funnel-shifter request order.
// Optional per-SSM delivered-word counters are enabled by defining SSM_ARB_STATS_EN.
module ssm_word_demux_arb #(
    parameter int NUM_SSM   = 4,
    parameter int WORD_W    = 128,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_dec,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic [NUM_SSM-1:0]          ssm_rd_en,
    output logic [NUM_SSM*WORD_W-1:0]   ssm_data,
    output logic [NUM_SSM-1:0]          ssm_avail,
    output logic                        busy,
    output logic                        underflow_err,
    output logic [NUM_SSM*16-1:0]       stat_words
);

    localparam int TOK_D = NUM_SSM * BUF_DEPTH;
    localparam int SW    = $clog2(NUM_SSM);
    localparam int PW    = $clog2(BUF_DEPTH);
    localparam int TPW   = $clog2(TOK_D);
    localparam int TCW   = $clog2(TOK_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clr;

    logic [WORD_W-1:0]  r_mem  [NUM_SSM][BUF_DEPTH];
    logic [PW-1:0]      r_wptr [NUM_SSM];
    logic [PW-1:0]      r_rptr [NUM_SSM];
    logic [PW:0]        r_cnt  [NUM_SSM];
    logic [WORD_W-1:0]  r_head [NUM_SSM];

    logic [SW-1:0]      r_tok [TOK_D];
    logic [TPW-1:0]     r_tok_wptr;
    logic [TPW-1:0]     r_tok_rptr;
    logic [TCW-1:0]     r_tok_cnt;
    logic [SW-1:0]      r_prime_ssm;
    logic [TPW-1:0]     r_prime_k;
    logic               r_uflow;

    logic               w_accept;
    logic               w_tok_pop;
    logic [SW-1:0]      w_tgt;
    logic [NUM_SSM-1:0] w_wr;
    logic [NUM_SSM-1:0] w_pop;
    logic [NUM_SSM-1:0] w_uflow;
    logic [TPW-1:0]     w_tok_slot [NUM_SSM];
    logic [TCW-1:0]     w_push_n;
    logic [TPW-1:0]     w_tok_wptr_nxt;
    logic [TPW-1:0]     w_tok_rptr_nxt;
    logic [PW-1:0]      w_rptr_nxt [NUM_SSM];
    logic [PW:0]        w_cnt_nxt  [NUM_SSM];
    logic [WORD_W-1:0]  w_head_nxt [NUM_SSM];

    assign w_clr = rst | flush;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_dec) w_state_nxt = S_PRIME;
            S_PRIME: if (w_accept && (r_prime_k == TPW'(TOK_D - 1))) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (r_state != S_IDLE);
        in_ready = 1'b0;
        case (r_state)
            S_PRIME: in_ready = 1'b1;
            S_RUN:   in_ready = (r_tok_cnt != '0);
            default: in_ready = 1'b0;
        endcase
        if (w_clr) in_ready = 1'b0;
    end

    // Word routing: priming walks round-robin, running follows the token head
    always_comb begin
        w_accept  = in_valid & in_ready;
        w_tgt     = (r_state == S_PRIME) ? r_prime_ssm : r_tok[r_tok_rptr];
        w_tok_pop = w_accept & (r_state == S_RUN);
        for (int i = 0; i < NUM_SSM; i++) begin
            w_wr[i]    = w_accept & (w_tgt == SW'(i));
            w_pop[i]   = ssm_rd_en[i] & (r_cnt[i] != '0);
            w_uflow[i] = ssm_rd_en[i] & (r_cnt[i] == '0);
        end
    end

    // Same-cycle pops claim consecutive token slots in ascending SSM order
    always_comb begin
        logic [TPW:0] v_sum;
        w_push_n = '0;
        v_sum    = '0;
        for (int i = 0; i < NUM_SSM; i++) begin
            v_sum = {1'b0, r_tok_wptr} + (TPW+1)'(w_push_n);
            if (v_sum >= (TPW+1)'(TOK_D)) v_sum = v_sum - (TPW+1)'(TOK_D);
            w_tok_slot[i] = v_sum[TPW-1:0];
            if (w_pop[i]) w_push_n = w_push_n + TCW'(1);
        end
        v_sum = {1'b0, r_tok_wptr} + (TPW+1)'(w_push_n);
        if (v_sum >= (TPW+1)'(TOK_D)) v_sum = v_sum - (TPW+1)'(TOK_D);
        w_tok_wptr_nxt = v_sum[TPW-1:0];
        w_tok_rptr_nxt = r_tok_rptr;
        if (w_tok_pop) begin
            w_tok_rptr_nxt = (r_tok_rptr == TPW'(TOK_D - 1)) ? '0 : r_tok_rptr + TPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_tok_wptr  <= '0;
            r_tok_rptr  <= '0;
            r_tok_cnt   <= '0;
            r_prime_ssm <= '0;
            r_prime_k   <= '0;
            r_uflow     <= 1'b0;
        end else begin
            r_tok_wptr <= w_tok_wptr_nxt;
            r_tok_rptr <= w_tok_rptr_nxt;
            r_tok_cnt  <= r_tok_cnt + w_push_n - TCW'(w_tok_pop);
            if ((r_state == S_PRIME) && w_accept) begin
                r_prime_k   <= r_prime_k + TPW'(1);
                r_prime_ssm <= (r_prime_ssm == SW'(NUM_SSM - 1)) ? '0 : r_prime_ssm + SW'(1);
            end
            if (|w_uflow) r_uflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SSM; i++) begin
            if (w_pop[i]) r_tok[w_tok_slot[i]] <= SW'(i);
        end
    end

    // Head word is registered so in_data never reaches ssm_data combinationally
    always_comb begin
        for (int i = 0; i < NUM_SSM; i++) begin
            w_rptr_nxt[i] = r_rptr[i] + PW'(w_pop[i]);
            w_cnt_nxt[i]  = r_cnt[i] + (PW+1)'(w_wr[i]) - (PW+1)'(w_pop[i]);
            w_head_nxt[i] = r_head[i];
            if (w_cnt_nxt[i] != '0) begin
                w_head_nxt[i] = (w_wr[i] && (r_wptr[i] == w_rptr_nxt[i])) ?
                                in_data : r_mem[i][w_rptr_nxt[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SSM; i++) begin
            if (w_clr) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
                r_head[i] <= '0;
            end else begin
                r_rptr[i] <= w_rptr_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
                r_head[i] <= w_head_nxt[i];
                if (w_wr[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SSM; i++) begin
            if (w_wr[i]) r_mem[i][r_wptr[i]] <= in_data;
        end
    end

    assign underflow_err = r_uflow;

    for (genvar g = 0; g < NUM_SSM; g++) begin : g_out
        assign ssm_data[g*WORD_W +: WORD_W] = r_head[g];
        assign ssm_avail[g]                 = (r_cnt[g] != '0);
    end

`ifdef SSM_ARB_STATS_EN
    logic [15:0] r_stat [NUM_SSM];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SSM; i++) begin
            if (w_clr) begin
                r_stat[i] <= '0;
            end else if (w_wr[i] && (r_stat[i] != 16'hFFFF)) begin
                r_stat[i] <= r_stat[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SSM; g++) begin : g_stat
        assign stat_words[g*16 +: 16] = r_stat[g];
    end
`else
    assign stat_words = '0;
`endif

endmodule
